// File: rtl/output_port_arbiter_pkg.sv
// Shared router constants for the per-output-port arbiter.
// Port numbering, packet-length width and arbiter state encoding.
package output_port_arbiter_pkg;

  localparam int NUM_PORTS = 5;

  localparam int PORT_N  = 0;
  localparam int PORT_E  = 1;
  localparam int PORT_S  = 2;
  localparam int PORT_W  = 3;
  localparam int PORT_PE = 4;

  localparam int PKT_LEN_W = 4;

  typedef enum logic {
    ARB_IDLE,
    ARB_XFER
  } arb_state_t;

endpackage

// File: rtl/output_port_arbiter_if.sv
// Request/grant bundle between input ports and one output arbiter.
// master: req, pkt_len, out_ready; slave: grant, grant_idx, busy, pkt_done.
interface output_port_arbiter_if
  import output_port_arbiter_pkg::*;
#(
  parameter int NUM_REQ = NUM_PORTS,
  parameter int LEN_W   = PKT_LEN_W
) ();

  localparam int IDX_W = $clog2(NUM_REQ);

  logic [NUM_REQ-1:0] req;
  logic [LEN_W-1:0]   pkt_len [NUM_REQ];
  logic               out_ready;
  logic [NUM_REQ-1:0] grant;
  logic [IDX_W-1:0]   grant_idx;
  logic               busy;
  logic               pkt_done;

  modport master (
    output req,
    output pkt_len,
    output out_ready,
    input  grant,
    input  grant_idx,
    input  busy,
    input  pkt_done
  );

  modport slave (
    input  req,
    input  pkt_len,
    input  out_ready,
    output grant,
    output grant_idx,
    output busy,
    output pkt_done
  );

endinterface

// File: rtl/output_port_arbiter_rr_pick.sv
// Rotated priority encoder: first set req bit at or above ptr, wrapping.
// Ports: req, ptr in; win (one-hot), win_idx, any out.
module rr_pick #(
  parameter int N = 5
) (
  input  logic [N-1:0]         req,
  input  logic [$clog2(N)-1:0] ptr,
  output logic [N-1:0]         win,
  output logic [$clog2(N)-1:0] win_idx,
  output logic                 any
);

  always_comb begin
    int j;
    win     = '0;
    win_idx = '0;
    any     = 1'b0;
    j       = 0;
    for (int i = 0; i < N; i++) begin
      j = int'(ptr) + i;
      if (j >= N) j = j - N;
      if (!any && req[j]) begin
        any     = 1'b1;
        win[j]  = 1'b1;
        win_idx = ($clog2(N))'(j);
      end
    end
  end

endmodule

// File: rtl/output_port_arbiter.sv
// Round-robin packet arbiter for one router output link.
// Ports: clk, rst (sync, active-low), bus (slave side of the arbiter bundle).
module output_port_arbiter
  import output_port_arbiter_pkg::*;
#(
  parameter int NUM_REQ = NUM_PORTS,
  parameter int LEN_W   = PKT_LEN_W
) (
  input  logic                 clk,
  input  logic                 rst,
  output_port_arbiter_if.slave bus
);

  localparam int IDX_W = $clog2(NUM_REQ);
  localparam int CNT_W = LEN_W + 1;

  arb_state_t         state_q, state_d;
  logic [NUM_REQ-1:0] grant_q, grant_d;
  logic [IDX_W-1:0]   idx_q, idx_d;
  logic               busy_q, busy_d;
  logic               done_q, done_d;
  logic [IDX_W-1:0]   ptr_q, ptr_d;
  logic [CNT_W-1:0]   cnt_q, cnt_d;

  logic [NUM_REQ-1:0] win;
  logic [IDX_W-1:0]   win_idx;
  logic               win_any;
  logic [LEN_W-1:0]   win_len;
  logic [CNT_W-1:0]   len_ext;

  rr_pick #(.N(NUM_REQ)) u_pick (
    .req     (bus.req),
    .ptr     (ptr_q),
    .win     (win),
    .win_idx (win_idx),
    .any     (win_any)
  );

  // Length 0 stands for the full 2^LEN_W bytes.
  always_comb begin
    win_len = bus.pkt_len[win_idx];
    len_ext = (win_len == '0) ? CNT_W'(1 << LEN_W)
                              : {1'b0, win_len};
  end

  always_comb begin
    state_d = state_q;
    grant_d = grant_q;
    idx_d   = idx_q;
    busy_d  = busy_q;
    done_d  = 1'b0;
    ptr_d   = ptr_q;
    cnt_d   = cnt_q;
    unique case (state_q)
      ARB_IDLE: begin
        if (win_any) begin
          state_d = ARB_XFER;
          grant_d = win;
          idx_d   = win_idx;
          busy_d  = 1'b1;
          cnt_d   = len_ext;
        end
      end
      ARB_XFER: begin
        if (bus.out_ready) begin
          cnt_d = cnt_q - CNT_W'(1);
          if (cnt_q == CNT_W'(1)) begin
            state_d = ARB_IDLE;
            grant_d = '0;
            busy_d  = 1'b0;
            done_d  = 1'b1;
            ptr_d   = (idx_q == IDX_W'(NUM_REQ - 1))
                      ? '0 : idx_q + IDX_W'(1);
          end
        end
      end
      default: state_d = ARB_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (!rst) begin
      state_q <= ARB_IDLE;
      grant_q <= '0;
      idx_q   <= '0;
      busy_q  <= 1'b0;
      done_q  <= 1'b0;
      ptr_q   <= '0;
      cnt_q   <= '0;
    end else begin
      state_q <= state_d;
      grant_q <= grant_d;
      idx_q   <= idx_d;
      busy_q  <= busy_d;
      done_q  <= done_d;
      ptr_q   <= ptr_d;
      cnt_q   <= cnt_d;
    end
  end

  assign bus.grant     = grant_q;
  assign bus.grant_idx = idx_q;
  assign bus.busy      = busy_q;
  assign bus.pkt_done  = done_q;

endmodule

// File: tb/tb_output_port_arbiter.sv
// Self-checking bench for output_port_arbiter.
// Directed scenarios plus randomized traffic against a packet-level model.
module tb_output_port_arbiter;
  import output_port_arbiter_pkg::*;

  localparam int N  = NUM_PORTS;
  localparam int LW = PKT_LEN_W;
  localparam int IW = $clog2(N);

  logic clk = 1'b0;
  logic rst = 1'b0;

  always #5 clk = ~clk;

  output_port_arbiter_if #(.NUM_REQ(N), .LEN_W(LW)) bus ();

  output_port_arbiter #(.NUM_REQ(N), .LEN_W(LW)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  int tests = 0;
  int fails = 0;

  // Packet-level model: who owns the link and how many bytes remain.
  int m_owner = -1;
  int m_idx   = 0;
  int m_ptr   = 0;
  int m_left  = 0;
  bit m_done  = 1'b0;

  function automatic logic [N-1:0] e_grant();
    logic [N-1:0] g;
    g = '0;
    if (m_owner >= 0) g[m_owner] = 1'b1;
    return g;
  endfunction

  task automatic step();
    logic [N-1:0] r;
    int len [N];
    bit rdy, rs;
    r   = bus.req;
    rdy = bus.out_ready;
    rs  = rst;
    for (int i = 0; i < N; i++) len[i] = int'(bus.pkt_len[i]);
    @(posedge clk);
    #1;
    if (!rs) begin
      m_owner = -1; m_idx = 0; m_ptr = 0;
      m_left  = 0;  m_done = 1'b0;
    end else begin
      m_done = 1'b0;
      if (m_owner < 0) begin
        for (int k = 0; k < N; k++) begin
          int c;
          c = (m_ptr + k) % N;
          if (m_owner < 0 && r[c]) m_owner = c;
        end
        if (m_owner >= 0) begin
          m_idx  = m_owner;
          m_left = (len[m_owner] == 0) ? (1 << LW) : len[m_owner];
        end
      end else if (rdy) begin
        m_left--;
        if (m_left == 0) begin
          m_done  = 1'b1;
          m_ptr   = (m_owner + 1) % N;
          m_owner = -1;
        end
      end
    end
  endtask

  task automatic clear_in();
    bus.req       = '0;
    bus.out_ready = 1'b1;
    for (int i = 0; i < N; i++) bus.pkt_len[i] = '0;
  endtask

  task automatic do_reset();
    clear_in();
    rst = 1'b0;
    step();
    rst = 1'b1;
  endtask

  // Steps until pkt_done; n = steps taken, or -1 if the budget ran out.
  task automatic wait_done(output int n);
    n = -1;
    for (int c = 1; c <= 64; c++) begin
      step();
      if (bus.pkt_done === 1'b1) begin
        n = c;
        return;
      end
    end
  endtask

  task automatic test_reset();
    clear_in();
    rst = 1'b0;
    step();
    bus.req = '1;
    step();
    tests++;
    if (bus.grant !== '0 || bus.busy !== 1'b0 ||
        bus.pkt_done !== 1'b0 || bus.grant_idx !== '0) begin
      fails++;
      $display("FAIL reset: grant=%b busy=%b done=%b idx=%0d want 0",
               bus.grant, bus.busy, bus.pkt_done, bus.grant_idx);
    end
    rst = 1'b1;
    bus.req = '0;
    step();
    tests++;
    if (bus.grant !== '0 || bus.busy !== 1'b0) begin
      fails++;
      $display("FAIL idle_noreq: grant=%b busy=%b want 0",
               bus.grant, bus.busy);
    end
  endtask

  task automatic test_single();
    int n;
    do_reset();
    bus.req = 5'b00100;
    bus.pkt_len[2] = 4'd3;
    step();
    tests++;
    if (bus.grant !== 5'b00100 || bus.grant_idx !== 3'd2 ||
        bus.busy !== 1'b1) begin
      fails++;
      $display("FAIL single_grant: grant=%b idx=%0d busy=%b want 00100 2 1",
               bus.grant, bus.grant_idx, bus.busy);
    end
    bus.req = '0;
    wait_done(n);
    tests++;
    if (n != 3) begin
      fails++;
      $display("FAIL single_beats: got %0d want 3", n);
    end
    tests++;
    if (bus.grant !== '0 || bus.busy !== 1'b0) begin
      fails++;
      $display("FAIL single_release: grant=%b busy=%b want 0",
               bus.grant, bus.busy);
    end
    step();
    tests++;
    if (bus.pkt_done !== 1'b0 || bus.grant !== '0) begin
      fails++;
      $display("FAIL single_after: done=%b grant=%b want 0 0",
               bus.pkt_done, bus.grant);
    end
  endtask

  task automatic test_rotation();
    logic [N-1:0] g;
    do_reset();
    bus.req = '1;
    for (int i = 0; i < N; i++) bus.pkt_len[i] = 4'd1;
    for (int p = 0; p < 2 * N; p++) begin
      g = '0;
      g[p % N] = 1'b1;
      step();
      tests++;
      if (bus.grant !== g || bus.grant_idx !== IW'(p % N)) begin
        fails++;
        $display("FAIL rotate_grant[%0d]: grant=%b idx=%0d want %b %0d",
                 p, bus.grant, bus.grant_idx, g, p % N);
      end
      step();
      tests++;
      if (bus.pkt_done !== 1'b1 || bus.grant !== '0) begin
        fails++;
        $display("FAIL rotate_gap[%0d]: done=%b grant=%b want 1 0",
                 p, bus.pkt_done, bus.grant);
      end
    end
  endtask

  task automatic test_backpressure();
    bit pat [4] = '{1'b1, 1'b0, 1'b0, 1'b1};
    logic [N-1:0] g;
    do_reset();
    bus.req = 5'b00010;
    bus.pkt_len[1] = 4'd2;
    step();
    bus.req = '0;
    for (int i = 0; i < 4; i++) begin
      bus.out_ready = pat[i];
      g = (i < 3) ? 5'b00010 : 5'b00000;
      step();
      tests++;
      if (bus.grant !== g || bus.pkt_done !== (i == 3)) begin
        fails++;
        $display("FAIL stall[%0d]: grant=%b done=%b want %b %0d",
                 i, bus.grant, bus.pkt_done, g, i == 3);
      end
    end
    bus.out_ready = 1'b1;
  endtask

  task automatic test_len_zero();
    int n;
    do_reset();
    bus.req = 5'b01000;
    bus.pkt_len[3] = 4'd0;
    step();
    tests++;
    if (bus.grant_idx !== 3'd3) begin
      fails++;
      $display("FAIL len0_idx: got %0d want 3", bus.grant_idx);
    end
    bus.req = '0;
    wait_done(n);
    tests++;
    if (n != 16) begin
      fails++;
      $display("FAIL len0_beats: got %0d want 16", n);
    end
  endtask

  task automatic test_mid_change();
    int n;
    do_reset();
    bus.req = 5'b00001;
    bus.pkt_len[0] = 4'd4;
    step();
    bus.req = '0;
    bus.pkt_len[0] = 4'd1;
    wait_done(n);
    tests++;
    if (n != 4) begin
      fails++;
      $display("FAIL mid_change_beats: got %0d want 4", n);
    end
  endtask

  task automatic test_reset_mid();
    bus.req = 5'b00100;
    bus.pkt_len[2] = 4'd4;
    step();
    tests++;
    if (bus.grant !== 5'b00100) begin
      fails++;
      $display("FAIL rstmid_grant: got %b want 00100", bus.grant);
    end
    step();
    rst = 1'b0;
    step();
    tests++;
    if (bus.grant !== '0 || bus.busy !== 1'b0 ||
        bus.pkt_done !== 1'b0) begin
      fails++;
      $display("FAIL rstmid_abort: grant=%b busy=%b done=%b want 0",
               bus.grant, bus.busy, bus.pkt_done);
    end
    rst = 1'b1;
    bus.req = '1;
    step();
    tests++;
    if (bus.grant !== 5'b00001) begin
      fails++;
      $display("FAIL rstmid_ptr: got %b want 00001", bus.grant);
    end
  endtask

  task automatic test_random();
    do_reset();
    for (int cyc = 0; cyc < 800; cyc++) begin
      bus.req = N'($urandom);
      for (int i = 0; i < N; i++) bus.pkt_len[i] = LW'($urandom);
      bus.out_ready = ($urandom_range(0, 3) != 0);
      rst = ($urandom_range(0, 99) != 0);
      step();
      tests++;
      if (bus.grant !== e_grant() || bus.grant_idx !== IW'(m_idx) ||
          bus.busy !== (m_owner >= 0) || bus.pkt_done !== m_done) begin
        fails++;
        $display("FAIL random[%0d]: g=%b i=%0d b=%b d=%b want %b %0d %0d %0d",
                 cyc, bus.grant, bus.grant_idx, bus.busy, bus.pkt_done,
                 e_grant(), m_idx, m_owner >= 0, m_done);
      end
      tests++;
      if (!$onehot0(bus.grant) || (bus.busy !== (bus.grant != '0)) ||
          (bus.pkt_done && bus.grant != '0)) begin
        fails++;
        $display("FAIL invariant[%0d]: grant=%b busy=%b done=%b",
                 cyc, bus.grant, bus.busy, bus.pkt_done);
      end
    end
    rst = 1'b1;
  endtask

  initial begin
    test_reset();
    test_single();
    test_rotation();
    test_backpressure();
    test_len_zero();
    test_mid_change();
    test_reset_mid();
    test_random();
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
